// File: rtl/cpu_pkg.sv
// Shared constants and types for the cpu_controller sequencer:
// opcodes, ext codes, halt word, FSM states, branch conditions, flag bits.
package cpu_pkg;

  localparam logic [3:0] OPC_RR   = 4'h0;
  localparam logic [3:0] OPC_I1   = 4'h1;
  localparam logic [3:0] OPC_I2   = 4'h2;
  localparam logic [3:0] OPC_I3   = 4'h3;
  localparam logic [3:0] OPC_I5   = 4'h5;
  localparam logic [3:0] OPC_I9   = 4'h9;
  localparam logic [3:0] OPC_CMPI = 4'hB;
  localparam logic [3:0] OPC_BCC  = 4'hC;
  localparam logic [3:0] OPC_ID   = 4'hD;

  localparam logic [3:0] EXT_CMP  = 4'hB;

  localparam logic [15:0] HALT_INSN = 16'h4000;
  localparam logic [4:0]  LOAD_NONE = 5'b10000;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } state_e;

  typedef enum logic [3:0] {
    CC_EQ = 4'h0,
    CC_NE = 4'h1,
    CC_CS = 4'h2,
    CC_CC = 4'h3,
    CC_HI = 4'h4,
    CC_LS = 4'h5,
    CC_LT = 4'h6,
    CC_GE = 4'h7,
    CC_AL = 4'hE
  } cond_e;

endpackage

// File: rtl/cpu_insn_decode.sv
// Combinational instruction decode: IR -> datapath controls and class bits.
// Ports: ir_i; dst_o, reg_a_o, reg_b_o, imm_o, op_o, sel_imm_o,
//   is_alu_o, is_cmp_o, is_branch_o. Bcc decoded only with CPU_BRANCH_EN.
module cpu_insn_decode
  import cpu_pkg::*;
(
  input  logic [15:0] ir_i,
  output logic [3:0]  dst_o,
  output logic [3:0]  reg_a_o,
  output logic [3:0]  reg_b_o,
  output logic [7:0]  imm_o,
  output logic [7:0]  op_o,
  output logic        sel_imm_o,
  output logic        is_alu_o,
  output logic        is_cmp_o,
  output logic        is_branch_o
);

  logic [3:0] opc;
  logic [3:0] rd;
  logic [3:0] ext;
  logic [3:0] rs;
  logic [7:0] imm;

  assign opc = ir_i[15:12];
  assign rd  = ir_i[11:8];
  assign ext = ir_i[7:4];
  assign rs  = ir_i[3:0];
  assign imm = ir_i[7:0];

  logic is_rr;
  logic is_immf;
  logic is_bcc;

  assign is_rr   = (opc == OPC_RR);
  assign is_immf = opc inside {OPC_I1, OPC_I2, OPC_I3, OPC_I5,
                               OPC_I9, OPC_ID, OPC_CMPI};

`ifdef CPU_BRANCH_EN
  assign is_bcc = (opc == OPC_BCC);
`else
  assign is_bcc = 1'b0;
`endif

  always_comb begin
    dst_o       = 4'h0;
    reg_a_o     = 4'h0;
    reg_b_o     = 4'h0;
    imm_o       = 8'h00;
    op_o        = 8'h00;
    sel_imm_o   = 1'b0;
    is_alu_o    = 1'b0;
    is_cmp_o    = 1'b0;
    is_branch_o = 1'b0;
    unique case (1'b1)
      is_rr: begin
        dst_o    = rd;
        reg_a_o  = rd;
        reg_b_o  = rs;
        op_o     = {4'h0, ext};
        is_alu_o = 1'b1;
        is_cmp_o = (ext == EXT_CMP);
      end
      is_immf: begin
        dst_o     = rd;
        reg_a_o   = rd;
        imm_o     = imm;
        op_o      = {opc, 4'h0};
        sel_imm_o = 1'b1;
        is_alu_o  = 1'b1;
        is_cmp_o  = (opc == OPC_CMPI);
      end
      is_bcc: begin
        is_branch_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Fetch/decode/execute sequencer for the 16-bit datapath; owns FSM, PC, IR, PSR.
// Ports: CLK, CLR (async high), imem_req/addr/ack/data, flags in;
//   loadReg, readRegA/B, Imm, op, selectImm, psr, halted out.
//   Optional conditional branches on opc C when CPU_BRANCH_EN is defined.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int               ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              CLR,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_data,
  input  logic [4:0]        flags,
  output logic [4:0]        loadReg,
  output logic [3:0]        readRegA,
  output logic [3:0]        readRegB,
  output logic [7:0]        Imm,
  output logic [7:0]        op,
  output logic              selectImm,
  output logic [4:0]        psr,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [4:0]        psr_q, psr_d;
  // Cleared by CLR, set on the first edge after release so that
  // the fetch request never rises in the same cycle CLR falls.
  logic              run_q;

  logic [3:0] dst;
  logic       is_alu;
  logic       is_cmp;
  logic       is_branch;

  cpu_insn_decode u_dec (
    .ir_i        (ir_q),
    .dst_o       (dst),
    .reg_a_o     (readRegA),
    .reg_b_o     (readRegB),
    .imm_o       (Imm),
    .op_o        (op),
    .sel_imm_o   (selectImm),
    .is_alu_o    (is_alu),
    .is_cmp_o    (is_cmp),
    .is_branch_o (is_branch)
  );

  logic              taken;
  logic [ADDR_W-1:0] disp;

  assign disp = ADDR_W'(signed'(ir_q[7:0]));

  // Condition is judged against the latched PSR, not live flags.
  always_comb begin
    taken = 1'b0;
    case (ir_q[11:8])
      CC_EQ:   taken =  psr_q[FLAG_Z];
      CC_NE:   taken = !psr_q[FLAG_Z];
      CC_CS:   taken =  psr_q[FLAG_C];
      CC_CC:   taken = !psr_q[FLAG_C];
      CC_HI:   taken =  psr_q[FLAG_L];
      CC_LS:   taken = !psr_q[FLAG_L];
      CC_LT:   taken =  psr_q[FLAG_N];
      CC_GE:   taken = !psr_q[FLAG_N];
      CC_AL:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      psr_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      psr_q   <= psr_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    psr_d   = psr_q;
    unique case (state_q)
      ST_FETCH: begin
        if (run_q && imem_ack) begin
          ir_d    = imem_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = (ir_q == HALT_INSN) ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        if (is_branch && taken) begin
          pc_d = pc_q + disp;
        end else begin
          pc_d = pc_q + ADDR_W'(1);
        end
        if (is_alu) begin
          psr_d = flags;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  assign imem_req  = run_q && (state_q == ST_FETCH);
  assign imem_addr = pc_q;
  assign loadReg   = (state_q == ST_EXEC && is_alu) ? {is_cmp, dst}
                                                    : LOAD_NONE;
  assign psr       = psr_q;
  assign halted    = (state_q == ST_HALT);

endmodule
